dbus_sram_ctrl: RTL and testbench
=================================

Name: dbus_sram_ctrl

Overview:
- Data-bus slave that sits directly downstream of the load/store unit. It consumes the LSU's level-held load/store request and returns a one-cycle ack with read data.
- Drives a single-port synchronous data SRAM: 1-cycle read latency, per-byte write enables.
- Performs store byte-lane steering, alignment and range checks, and flush suppression.
- Supports a configurable number of wait states to model slower memories.

Parameters:
- MEM_AW, 12: SRAM word-address width; the memory holds 2^MEM_AW 32-bit words.
- WAIT_STATES, 0: extra cycles (0..15) inserted between SRAM access and ack.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lsu_addr_i  in  32  byte address of the access.
- lsu_ld_req_i  in  1  load request, held until ack.
- lsu_st_req_i  in  1  store request, held until ack.
- lsu_st_ops_i  in  2  store size: 00 none, 01 SB, 10 SH, 11 SW.
- lsu_w_data_i  in  32  store data, right-aligned.
- lsu_flush_i  in  1  pipeline flush of the LSU stage.
- dbus_r_data_o  out  32  full read word; valid only when dbus_ack_o=1, otherwise 0.
- dbus_ack_o  out  1  one-cycle completion pulse.
- dbus_err_o  out  1  asserted with ack when the access faulted.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  4  SRAM byte enables.
- mem_addr_o  out  MEM_AW  SRAM word address, lsu_addr_i[MEM_AW+1:2].
- mem_w_data_o  out  32  lane-replicated store data.
- mem_r_data_i  in  32  SRAM read data, valid the cycle after mem_req_o, held until the next mem_req_o.

Behaviour:
- Reset: FSM goes to IDLE and the wait counter clears.
- All outputs are 0 while in reset and in IDLE without a request. Reset mid-access abandons the access; no ack is issued afterwards.
- FSM states: IDLE, WAIT, RESP.
- IDLE, req = ld_req|st_req, flush=0:
  - If the request is legal: mem_req_o=1 combinationally in the same cycle. Load counter with WAIT_STATES and go to WAIT.
  - If the request faults: no mem_req_o; go to RESP.
- IDLE with flush=1, or no request: stay in IDLE, no SRAM access.
- WAIT: if counter==0, drive dbus_ack_o=1 and dbus_r_data_o=mem_r_data_i, then go to IDLE; otherwise decrement the counter.
- RESP: dbus_ack_o=1 and dbus_err_o=1 for one cycle, r_data=0, then go to IDLE.
- Latency: a legal access is acked 1+WAIT_STATES cycles after the request cycle. A faulting access is acked exactly 1 cycle after.
- Back-to-back: the next request is sampled in the cycle after ack, giving a minimum one-cycle bubble.
- Load: mem_we_o=0 and mem_be_o=1111. The full word is returned; lane extraction and extension are the LSU's job. Loads never raise a misalignment error.
- Store (st_req=1; takes priority if ld_req is also 1): mem_we_o=1.
  - SB: be=1<<addr[1:0], data={4{w[7:0]}}.
  - SH: be=addr[1]?1100:0011, data={2{w[15:0]}}.
  - SW: be=1111, data=w.
- Fault conditions:
  - store with st_ops=00;
  - SH with addr[0]=1;
  - SW with addr[1:0]!=00;
  - any access with addr[31:MEM_AW+2]!=0 (out of range).
- Flush in WAIT: the SRAM access already issued stands, and the counter continues. The ack is suppressed (ack, err and r_data stay 0) and the FSM returns to IDLE.
- Flush in RESP: the error ack is suppressed; go to IDLE.
- Flush and request in the same IDLE cycle: the request is dropped.
- Inputs are sampled only in IDLE; changes to addr or data during WAIT are ignored.

Test Plan:
- Load, WAIT_STATES=0: SRAM word[0x40]=0xDEADBEEF, ld_req addr 0x100 at cycle n. Expect mem_req_o=1, we=0, be=1111, mem_addr=0x40 at n; ack=1 with r_data=0xDEADBEEF at n+1; ack=0 at n+2.
- Byte store: st_ops=SB, addr 0x103, w_data 0x000000AB. Expect be=1000 and mem_w_data=0xABABABAB at n; ack at n+1 with err=0. A following SH at 0x102 with data 0x1234 gives be=1100 and mem_w_data=0x12341234.
- Misaligned/out-of-range: SH at 0x101 → no mem_req_o, ack=1 and err=1 at n+1. LW at 0x4000 with MEM_AW=12 → same error response. SW at 0x102 → same error response.
- Wait states, WAIT_STATES=2: back-to-back LW 0x0 and LW 0x4. Acks at n+3 and n+7; the second mem_req_o at n+4.
- Flush mid-access, WAIT_STATES=2: SW at 0x8 issued at n, flush at n+1. The SRAM write occurs, no ack at n+3, and a new request is accepted at n+3 once the FSM is back in IDLE.
- Reset mid-access: rst_n deasserted at n+1 during WAIT. All outputs go to 0 immediately, and no ack follows after release.

Source files
------------

// File: rtl/dbus_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dbus_sram_ctrl
// Purpose  : LSU data-bus slave driving a single-port 1-cycle synchronous SRAM
// Revision : 1.0 - initial release
// ============================================================================
module dbus_sram_ctrl #(
  parameter int MEM_AW      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       lsu_addr_i,
  input  logic              lsu_ld_req_i,
  input  logic              lsu_st_req_i,
  input  logic [1:0]        lsu_st_ops_i,
  input  logic [31:0]       lsu_w_data_i,
  input  logic              lsu_flush_i,
  output logic [31:0]       dbus_r_data_o,
  output logic              dbus_ack_o,
  output logic              dbus_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_w_data_o,
  input  logic [31:0]       mem_r_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        is_st;
  logic        accept;
  logic        fault;
  logic        issue;
  logic        st_fault;
  logic        wait_ack;
  logic        resp_ack;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [31:0] addr_hi;

  assign is_st   = lsu_st_req_i;
  assign addr_hi = lsu_addr_i >> (MEM_AW + 2);

  // Store lane steering: narrow data is replicated so the byte enables pick the lane.
  always_comb begin
    st_be    = 4'b0000;
    st_data  = lsu_w_data_i;
    st_fault = 1'b0;
    case (lsu_st_ops_i)
      2'b01: begin
        st_be   = 4'b0001 << lsu_addr_i[1:0];
        st_data = {4{lsu_w_data_i[7:0]}};
      end
      2'b10: begin
        st_be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        st_data  = {2{lsu_w_data_i[15:0]}};
        st_fault = lsu_addr_i[0];
      end
      2'b11: begin
        st_be    = 4'b1111;
        st_fault = (lsu_addr_i[1:0] != 2'b00);
      end
      default: st_fault = 1'b1;
    endcase
  end

  assign fault  = (addr_hi != 32'd0) | (is_st & st_fault);
  assign accept = rst_n & (state_q == ST_IDLE) & (lsu_ld_req_i | lsu_st_req_i) & ~lsu_flush_i;
  assign issue  = accept & ~fault;

  assign mem_req_o    = issue;
  assign mem_we_o     = issue & is_st;
  assign mem_be_o     = issue ? (is_st ? st_be : 4'b1111) : 4'b0000;
  assign mem_addr_o   = issue ? lsu_addr_i[MEM_AW+1:2] : '0;
  assign mem_w_data_o = (issue & is_st) ? st_data : 32'd0;

  assign wait_ack      = (state_q == ST_WAIT) & (cnt_q == 4'd0) & ~lsu_flush_i;
  assign resp_ack      = (state_q == ST_RESP) & ~lsu_flush_i;
  assign dbus_ack_o    = wait_ack | resp_ack;
  assign dbus_err_o    = resp_ack;
  assign dbus_r_data_o = wait_ack ? mem_r_data_i : 32'd0;

  // The counter free-runs down to zero, so a flushed access keeps counting harmlessly.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (fault) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (lsu_flush_i || (cnt_q == 4'd0)) state_d = ST_IDLE;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dbus_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_sram_ctrl
// Purpose  : directed bench for dbus_sram_ctrl (WAIT_STATES=0 and =2 instances)
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_sram_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] a_addr, a_wd, a_rd, a_mwd, a_mrd;
  logic        a_ld, a_st, a_fl, a_ack, a_err, a_mreq, a_mwe;
  logic [1:0]  a_ops;
  logic [3:0]  a_mbe;
  logic [11:0] a_maddr;

  logic [31:0] b_addr, b_wd, b_rd, b_mwd, b_mrd;
  logic        b_ld, b_st, b_fl, b_ack, b_err, b_mreq, b_mwe;
  logic [1:0]  b_ops;
  logic [3:0]  b_mbe;
  logic [11:0] b_maddr;

  logic [31:0] mem0 [0:4095];
  logic [31:0] mem1 [0:4095];

  dbus_sram_ctrl #(.MEM_AW(12), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .lsu_addr_i(a_addr), .lsu_ld_req_i(a_ld), .lsu_st_req_i(a_st),
    .lsu_st_ops_i(a_ops), .lsu_w_data_i(a_wd), .lsu_flush_i(a_fl),
    .dbus_r_data_o(a_rd), .dbus_ack_o(a_ack), .dbus_err_o(a_err),
    .mem_req_o(a_mreq), .mem_we_o(a_mwe), .mem_be_o(a_mbe),
    .mem_addr_o(a_maddr), .mem_w_data_o(a_mwd), .mem_r_data_i(a_mrd)
  );

  dbus_sram_ctrl #(.MEM_AW(12), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .lsu_addr_i(b_addr), .lsu_ld_req_i(b_ld), .lsu_st_req_i(b_st),
    .lsu_st_ops_i(b_ops), .lsu_w_data_i(b_wd), .lsu_flush_i(b_fl),
    .dbus_r_data_o(b_rd), .dbus_ack_o(b_ack), .dbus_err_o(b_err),
    .mem_req_o(b_mreq), .mem_we_o(b_mwe), .mem_be_o(b_mbe),
    .mem_addr_o(b_maddr), .mem_w_data_o(b_mwd), .mem_r_data_i(b_mrd)
  );

  // Synchronous SRAM models: read data appears the cycle after the strobe and is held.
  always @(posedge clk) begin
    if (a_mreq) begin
      if (a_mwe) begin
        for (int i = 0; i < 4; i++)
          if (a_mbe[i]) mem0[a_maddr][8*i +: 8] = a_mwd[8*i +: 8];
      end else begin
        a_mrd <= mem0[a_maddr];
      end
    end
  end

  always @(posedge clk) begin
    if (b_mreq) begin
      if (b_mwe) begin
        for (int i = 0; i < 4; i++)
          if (b_mbe[i]) mem1[b_maddr][8*i +: 8] = b_mwd[8*i +: 8];
      end else begin
        b_mrd <= mem1[b_maddr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_set(input logic ld, input logic st, input logic [1:0] ops,
                       input logic [31:0] addr, input logic [31:0] wd, input logic fl);
    a_ld = ld; a_st = st; a_ops = ops; a_addr = addr; a_wd = wd; a_fl = fl;
    #1;
  endtask

  task automatic b_set(input logic ld, input logic st, input logic [1:0] ops,
                       input logic [31:0] addr, input logic [31:0] wd, input logic fl);
    b_ld = ld; b_st = st; b_ops = ops; b_addr = addr; b_wd = wd; b_fl = fl;
    #1;
  endtask

  task automatic a_fault(input string t, input logic ld, input logic st,
                         input logic [1:0] ops, input logic [31:0] addr);
    step(); a_set(ld, st, ops, addr, 32'h5555AAAA, 1'b0);
    chk({t, "_mreq"}, 32'(a_mreq), 32'd0);
    chk({t, "_ack_n"}, 32'(a_ack), 32'd0);
    step();
    chk({t, "_ack"}, 32'(a_ack), 32'd1);
    chk({t, "_err"}, 32'(a_err), 32'd1);
    chk({t, "_rd"}, a_rd, 32'd0);
    step(); a_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    chk({t, "_ack_done"}, 32'(a_ack), 32'd0);
  endtask

  initial begin
    a_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    b_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 4096; i++) begin
      mem0[i] = 32'd0;
      mem1[i] = 32'd0;
    end
    mem0[12'h040] = 32'hDEADBEEF;
    mem1[0]       = 32'h11111111;
    mem1[1]       = 32'h22222222;

    // Reset: outputs quiet even with a request presented
    step(); a_set(1'b1, 1'b0, 2'b00, 32'h100, 32'd0, 1'b0);
    chk("rst_mreq", 32'(a_mreq), 32'd0);
    chk("rst_ack", 32'(a_ack), 32'd0);
    chk("rst_be", 32'(a_mbe), 32'd0);
    chk("rst_b_ack", 32'(b_ack), 32'd0);
    a_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    step(); rst_n = 1'b1;
    step();
    chk("idle_mreq", 32'(a_mreq), 32'd0);
    chk("idle_rd", a_rd, 32'd0);

    // Load, zero wait states
    step(); a_set(1'b1, 1'b0, 2'b00, 32'h100, 32'd0, 1'b0);
    chk("ld_mreq", 32'(a_mreq), 32'd1);
    chk("ld_we", 32'(a_mwe), 32'd0);
    chk("ld_be", 32'(a_mbe), 32'hF);
    chk("ld_addr", 32'(a_maddr), 32'h40);
    chk("ld_ack_n", 32'(a_ack), 32'd0);
    step();
    chk("ld_ack", 32'(a_ack), 32'd1);
    chk("ld_err", 32'(a_err), 32'd0);
    chk("ld_rd", a_rd, 32'hDEADBEEF);
    chk("ld_bubble", 32'(a_mreq), 32'd0);
    step(); a_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    chk("ld_ack_done", 32'(a_ack), 32'd0);

    // Byte store then halfword store into the same word
    step(); a_set(1'b0, 1'b1, 2'b01, 32'h103, 32'h000000AB, 1'b0);
    chk("sb_mreq", 32'(a_mreq), 32'd1);
    chk("sb_we", 32'(a_mwe), 32'd1);
    chk("sb_be", 32'(a_mbe), 32'h8);
    chk("sb_wd", a_mwd, 32'hABABABAB);
    step();
    chk("sb_ack", 32'(a_ack), 32'd1);
    chk("sb_err", 32'(a_err), 32'd0);
    step(); a_set(1'b1, 1'b1, 2'b10, 32'h102, 32'h00001234, 1'b0);
    chk("sh_we", 32'(a_mwe), 32'd1);
    chk("sh_be", 32'(a_mbe), 32'hC);
    chk("sh_wd", a_mwd, 32'h12341234);
    step();
    chk("sh_ack", 32'(a_ack), 32'd1);
    step(); a_set(1'b1, 1'b0, 2'b00, 32'h100, 32'd0, 1'b0);
    step();
    chk("merge_rd", a_rd, 32'h1234BEEF);
    step(); a_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);

    // Faulting accesses
    a_fault("sh_mis", 1'b0, 1'b1, 2'b10, 32'h101);
    a_fault("lw_oor", 1'b1, 1'b0, 2'b00, 32'h4000);
    a_fault("sw_mis", 1'b0, 1'b1, 2'b11, 32'h102);
    a_fault("st_none", 1'b0, 1'b1, 2'b00, 32'h100);

    // Flush suppresses the error ack
    step(); a_set(1'b0, 1'b1, 2'b11, 32'h102, 32'd0, 1'b0);
    step(); a_set(1'b0, 1'b1, 2'b11, 32'h102, 32'd0, 1'b1);
    chk("fl_resp_ack", 32'(a_ack), 32'd0);
    chk("fl_resp_err", 32'(a_err), 32'd0);
    step(); a_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    chk("fl_resp_after", 32'(a_ack), 32'd0);

    // Flush with request in IDLE drops it
    step(); a_set(1'b1, 1'b0, 2'b00, 32'h100, 32'd0, 1'b1);
    chk("fl_idle_mreq", 32'(a_mreq), 32'd0);
    step(); a_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    chk("fl_idle_ack", 32'(a_ack), 32'd0);

    // Flush at the ack cycle with zero wait states
    step(); a_set(1'b1, 1'b0, 2'b00, 32'h100, 32'd0, 1'b0);
    step(); a_set(1'b1, 1'b0, 2'b00, 32'h100, 32'd0, 1'b1);
    chk("fl_w0_ack", 32'(a_ack), 32'd0);
    chk("fl_w0_rd", a_rd, 32'd0);
    step(); a_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);

    // Two wait states, back-to-back loads
    step(); b_set(1'b1, 1'b0, 2'b00, 32'h0, 32'd0, 1'b0);
    chk("ws_mreq0", 32'(b_mreq), 32'd1);
    step(); chk("ws_n1", 32'(b_ack), 32'd0);
    step(); chk("ws_n2", 32'(b_ack), 32'd0);
    step();
    chk("ws_ack0", 32'(b_ack), 32'd1);
    chk("ws_rd0", b_rd, 32'h11111111);
    chk("ws_bubble", 32'(b_mreq), 32'd0);
    step(); b_set(1'b1, 1'b0, 2'b00, 32'h4, 32'd0, 1'b0);
    chk("ws_mreq1", 32'(b_mreq), 32'd1);
    chk("ws_addr1", 32'(b_maddr), 32'd1);
    step(); chk("ws_n5", 32'(b_ack), 32'd0);
    step(); chk("ws_n6", 32'(b_ack), 32'd0);
    step();
    chk("ws_ack1", 32'(b_ack), 32'd1);
    chk("ws_rd1", b_rd, 32'h22222222);
    step(); b_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);

    // Flush mid-access: write stands, ack suppressed, new request accepted at n+3
    step(); b_set(1'b0, 1'b1, 2'b11, 32'h8, 32'hCAFEF00D, 1'b0);
    chk("fw_mreq", 32'(b_mreq), 32'd1);
    chk("fw_be", 32'(b_mbe), 32'hF);
    chk("fw_wd", b_mwd, 32'hCAFEF00D);
    step(); b_set(1'b0, 1'b1, 2'b11, 32'h8, 32'hCAFEF00D, 1'b1);
    chk("fw_n1", 32'(b_ack), 32'd0);
    step(); b_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    chk("fw_n2", 32'(b_ack), 32'd0);
    step(); b_set(1'b1, 1'b0, 2'b00, 32'h8, 32'd0, 1'b0);
    chk("fw_n3_ack", 32'(b_ack), 32'd0);
    chk("fw_n3_mreq", 32'(b_mreq), 32'd1);
    chk("fw_mem", mem1[2], 32'hCAFEF00D);
    step(); step(); step();
    chk("fw_rd_ack", 32'(b_ack), 32'd1);
    chk("fw_rd", b_rd, 32'hCAFEF00D);
    step(); b_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);

    // Reset mid-access
    step(); b_set(1'b1, 1'b0, 2'b00, 32'h4, 32'd0, 1'b0);
    chk("rm_mreq", 32'(b_mreq), 32'd1);
    step(); rst_n = 1'b0;
    b_set(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    chk("rm_ack", 32'(b_ack), 32'd0);
    chk("rm_err", 32'(b_err), 32'd0);
    chk("rm_rd", b_rd, 32'd0);
    chk("rm_mreq_rst", 32'(b_mreq), 32'd0);
    step(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rm_no_ack", 32'(b_ack), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
